picnic_commit_seq: RTL and testbench

Sequencer for one Picnic round's party commitments. For round `t` it walks parties `j = 0..NUM_PARTIES-1`, fetches each party's seed and aux from the seed store, drives the C2 commitment hasher (SM3, two compression blocks) and streams the 256-bit commitments downstream with valid/ready. It sits between the seed/tape generator and the challenge-hash absorber.

---
 rtl/picnic_pkg.sv | 18 +
 rtl/picnic_commit_seq.sv | 152 +++++++++++++++
 tb/tb_picnic_commit_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picnic_pkg.sv
// Shared widths and state encoding for the Picnic party-commitment sequencer.
package picnic_pkg;

    localparam int SEED_W   = 128;
    localparam int AUX_W    = 512;
    localparam int SALT_W   = 256;
    localparam int DIGEST_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HASH,
        ST_RELEASE,
        ST_EMIT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/picnic_commit_seq.sv
// Walks the parties of one Picnic round: fetch seed/aux, run the C2 hasher,
// stream each 256-bit commitment downstream.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | seed_req high for current party
// HASH    | h_start high, waiting for h_done
// RELEASE | h_start low, waiting for hasher to clear h_done
// EMIT    | cm_valid high, waiting for cm_ready
// FIN     | one-cycle done pulse
module picnic_commit_seq
    import picnic_pkg::*;
#(
    parameter int NUM_PARTIES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          t_round,
    input  logic [SALT_W-1:0]   salt,
    input  logic [7:0]          i_tag,
    output logic                seed_req,
    output logic [7:0]          seed_party,
    input  logic                seed_vld,
    input  logic [SEED_W-1:0]   seed_in,
    input  logic [AUX_W-1:0]    aux_in,
    output logic                h_start,
    output logic [SEED_W-1:0]   h_seed,
    output logic [AUX_W-1:0]    h_aux,
    output logic [SALT_W-1:0]   h_salt,
    output logic [7:0]          h_t,
    output logic [7:0]          h_j,
    output logic [7:0]          h_i,
    input  logic                h_done,
    input  logic [DIGEST_W-1:0] h_digest,
    output logic                cm_valid,
    input  logic                cm_ready,
    output logic [DIGEST_W-1:0] cm_data,
    output logic [7:0]          cm_party,
    output logic                cm_last,
    output logic                busy,
    output logic                done
);

    localparam logic [7:0] LAST_PARTY = 8'(NUM_PARTIES - 1);

    state_t                state_q, state_d;
    logic [7:0]            party_q, party_d;
    logic [7:0]            t_q, itag_q;
    logic [SALT_W-1:0]     salt_q;
    logic [SEED_W-1:0]     seed_q;
    logic [AUX_W-1:0]      aux_q;
    logic [DIGEST_W-1:0]   cm_data_q;
    logic                  seed_req_q, h_start_q, cm_valid_q, cm_last_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        party_d = party_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    party_d = '0;
                end
            end
            ST_FETCH: begin
                if (seed_vld) state_d = ST_HASH;
            end
            ST_HASH: begin
                if (h_done) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!h_done) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (cm_ready) begin
                    if (party_q == LAST_PARTY) begin
                        state_d = ST_FIN;
                    end else begin
                        party_d = party_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control outputs are decoded from the next state so they are registered
    // yet line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            party_q    <= '0;
            t_q        <= '0;
            itag_q     <= '0;
            salt_q     <= '0;
            seed_q     <= '0;
            aux_q      <= '0;
            cm_data_q  <= '0;
            seed_req_q <= 1'b0;
            h_start_q  <= 1'b0;
            cm_valid_q <= 1'b0;
            cm_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            party_q    <= party_d;
            seed_req_q <= (state_d == ST_FETCH);
            h_start_q  <= (state_d == ST_HASH);
            cm_valid_q <= (state_d == ST_EMIT);
            cm_last_q  <= (state_d == ST_EMIT) && (party_d == LAST_PARTY);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_FIN);
            if (state_q == ST_IDLE && start) begin
                t_q    <= t_round;
                salt_q <= salt;
                itag_q <= i_tag;
            end
            if (state_q == ST_FETCH && seed_vld) begin
                seed_q <= seed_in;
                aux_q  <= aux_in;
            end
            if (state_q == ST_HASH && h_done) begin
                cm_data_q <= h_digest;
            end
        end
    end

    assign seed_req   = seed_req_q;
    assign seed_party = party_q;
    assign h_start    = h_start_q;
    assign h_seed     = seed_q;
    assign h_aux      = aux_q;
    assign h_salt     = salt_q;
    assign h_t        = t_q;
    assign h_j        = party_q;
    assign h_i        = itag_q;
    assign cm_valid   = cm_valid_q;
    assign cm_data    = cm_data_q;
    assign cm_party   = party_q;
    assign cm_last    = cm_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_picnic_commit_seq.sv
// Bench for picnic_commit_seq: seed source, SM3 hasher model and a scoreboard of
// golden commitments; instance 0 has 3 parties, instance 1 has 2.
module tb_picnic_commit_seq;
    import picnic_pkg::*;

    localparam int HLAT = 66;
    localparam logic [255:0] SM3_IV  = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    localparam logic [511:0] ABC_BLK = {24'h616263, 1'b1, 423'd0, 64'd24};
    localparam logic [255:0] ABC_DIG = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;

    typedef struct packed {
        logic [255:0] dig;
        logic [7:0]   party;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1, start_r = 1'b0, sel = 1'b0;
    logic         seed_vld_src = 1'b0, seed_vld_x = 1'b0, seed_vld;
    logic [7:0]   t_round = '0, i_tag = '0;
    logic [255:0] salt = '0;
    logic [127:0] seed_in_r = '0;
    logic [511:0] aux_in_r = '0;
    logic         h_done_r = 1'b0, cm_ready_r = 1'b1;
    logic [255:0] h_digest_r = '0;
    logic [1:0]   start_w;

    logic [1:0]        seed_req_w, h_start_w, cm_valid_w, cm_last_w, busy_w, done_w;
    logic [1:0][7:0]   seed_party_w, h_t_w, h_j_w, h_i_w, cm_party_w;
    logic [1:0][127:0] h_seed_w;
    logic [1:0][511:0] h_aux_w;
    logic [1:0][255:0] h_salt_w, cm_data_w;

    logic         seed_req, h_start, cm_valid, cm_last, busy, done;
    logic [7:0]   seed_party, h_t, h_j, h_i, cm_party;
    logic [127:0] h_seed;
    logic [511:0] h_aux;
    logic [255:0] h_salt, cm_data;

    assign seed_vld = seed_vld_src | seed_vld_x;
    assign start_w  = {start_r & sel, start_r & ~sel};

    picnic_commit_seq #(.NUM_PARTIES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_w[0]), .t_round(t_round), .salt(salt), .i_tag(i_tag),
        .seed_req(seed_req_w[0]), .seed_party(seed_party_w[0]), .seed_vld(seed_vld),
        .seed_in(seed_in_r), .aux_in(aux_in_r), .h_start(h_start_w[0]), .h_seed(h_seed_w[0]),
        .h_aux(h_aux_w[0]), .h_salt(h_salt_w[0]), .h_t(h_t_w[0]), .h_j(h_j_w[0]), .h_i(h_i_w[0]),
        .h_done(h_done_r), .h_digest(h_digest_r), .cm_valid(cm_valid_w[0]), .cm_ready(cm_ready_r),
        .cm_data(cm_data_w[0]), .cm_party(cm_party_w[0]), .cm_last(cm_last_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    picnic_commit_seq #(.NUM_PARTIES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_w[1]), .t_round(t_round), .salt(salt), .i_tag(i_tag),
        .seed_req(seed_req_w[1]), .seed_party(seed_party_w[1]), .seed_vld(seed_vld),
        .seed_in(seed_in_r), .aux_in(aux_in_r), .h_start(h_start_w[1]), .h_seed(h_seed_w[1]),
        .h_aux(h_aux_w[1]), .h_salt(h_salt_w[1]), .h_t(h_t_w[1]), .h_j(h_j_w[1]), .h_i(h_i_w[1]),
        .h_done(h_done_r), .h_digest(h_digest_r), .cm_valid(cm_valid_w[1]), .cm_ready(cm_ready_r),
        .cm_data(cm_data_w[1]), .cm_party(cm_party_w[1]), .cm_last(cm_last_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    assign seed_req   = seed_req_w[sel];
    assign seed_party = seed_party_w[sel];
    assign h_start    = h_start_w[sel];
    assign h_seed     = h_seed_w[sel];
    assign h_aux      = h_aux_w[sel];
    assign h_salt     = h_salt_w[sel];
    assign h_t        = h_t_w[sel];
    assign h_j        = h_j_w[sel];
    assign h_i        = h_i_w[sel];
    assign cm_valid   = cm_valid_w[sel];
    assign cm_data    = cm_data_w[sel];
    assign cm_party   = cm_party_w[sel];
    assign cm_last    = cm_last_w[sel];
    assign busy       = busy_w[sel];
    assign done       = done_w[sel];

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Golden SM3
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rol(x, 9) ^ rol(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w[68];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
        for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rol(rol(a, 12) + e + rol(tj, j), 7);
            ss2 = ss1 ^ rol(a, 12);
            ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
            tt2 = gg + h + ss1 + w[j];
            d = c; c = rol(b, 9); b = a; a = tt1;
            h = g; g = rol(f, 19); f = e; e = p0(tt2);
        end
        return {a, b, c, d, e, f, g, h} ^ v;
    endfunction

    function automatic logic [255:0] sm3_commit(input logic [127:0] sd, input logic [511:0] ax,
                                                input logic [255:0] sl, input logic [7:0] t,
                                                input logic [7:0] j, input logic [7:0] i);
        logic [1023:0] m;
        m = {sd, ax, sl, t, j, i, 1'b1, 39'd0, 64'd920};
        return sm3_cf(sm3_cf(SM3_IV, m[1023:512]), m[511:0]);
    endfunction

    int           np_cur = 3, seed_delay = 0, stall_party = 255, stall_left = 0, hold_extra = 0;
    int           exp_party = 0, acc_count = 0, hash_count = 0, done_count = 0;
    logic [7:0]   t_cur = '0, i_cur = '0;
    logic [255:0] salt_cur = '0;
    exp_t         exp_q[$];

    // Seed source: answers each fetch and records the golden commitment for it.
    exp_t sd_e;
    always begin
        @(posedge clk); #1;
        if (seed_req && !reset) begin
            chk("seed_party", seed_party, 8'(exp_party));
            chk("fetch_order", acc_count, exp_party);
            repeat (seed_delay) begin
                @(posedge clk); #1;
                chk("seed_req_hold", seed_req, 1);
            end
            seed_in_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int k = 0; k < 16; k++) aux_in_r[32*k +: 32] = $urandom();
            if (exp_party == 0) aux_in_r = '0;
            sd_e.dig   = sm3_commit(seed_in_r, aux_in_r, salt_cur, t_cur, 8'(exp_party), i_cur);
            sd_e.party = 8'(exp_party);
            sd_e.last  = (exp_party == np_cur - 1);
            exp_q.push_back(sd_e);
            seed_vld_src = 1'b1;
            @(posedge clk); #1;
            seed_vld_src = 1'b0;
            exp_party++;
        end
    end

    // Hasher model: fixed latency, done held until h_start drops plus hold_extra cycles.
    logic [255:0] hm_dig;
    bit           hm_ok;
    int           hm_n;
    always begin
        @(posedge clk); #1;
        if (h_start && !h_done_r) begin
            hash_count++;
            hm_dig = sm3_commit(h_seed, h_aux, h_salt, h_t, h_j, h_i);
            hm_ok  = 1'b1;
            for (int k = 0; k < HLAT; k++) begin
                @(posedge clk); #1;
                if (!h_start) begin
                    hm_ok = 1'b0;
                    break;
                end
            end
            if (hm_ok) begin
                h_digest_r = hm_dig;
                h_done_r   = 1'b1;
                hm_n = 0;
                while (h_start && hm_n < 200) begin
                    @(posedge clk); #1;
                    hm_n++;
                end
                chk("h_start_drop", h_start, 0);
                repeat (hold_extra) begin
                    @(posedge clk); #1;
                    chk("no_rehash", h_start, 0);
                end
                h_done_r   = 1'b0;
                h_digest_r = '0;
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (cm_valid && acc_count == stall_party && stall_left > 0) begin
            cm_ready_r = 1'b0;
            stall_left--;
        end else begin
            cm_ready_r = 1'b1;
        end
    end

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    logic         held = 1'b0, held_l;
    logic [255:0] held_d;
    logic [7:0]   held_p;
    exp_t         mon_e;
    always @(negedge clk) begin
        if (done) done_count++;
        if (cm_valid) begin
            if (held) begin
                chk("stall_data", cm_data, held_d);
                chk("stall_party", cm_party, held_p);
                chk("stall_last", cm_last, held_l);
            end
            if (cm_ready_r) begin
                chk("cm_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("cm_data", cm_data, mon_e.dig);
                    chk("cm_party", cm_party, mon_e.party);
                    chk("cm_last", cm_last, mon_e.last);
                end
                acc_count++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                held_d = cm_data;
                held_p = cm_party;
                held_l = cm_last;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic chk_zero(input string pfx);
        chk({pfx, "_seed_req"}, seed_req, 0);
        chk({pfx, "_h_start"}, h_start, 0);
        chk({pfx, "_cm_valid"}, cm_valid, 0);
        chk({pfx, "_cm_last"}, cm_last, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_cm_data"}, cm_data, 0);
        chk({pfx, "_party"}, {seed_party, cm_party, h_j}, 0);
        chk({pfx, "_operands"}, (|h_seed) | (|h_aux) | (|h_salt) | (|h_t) | (|h_i), 0);
    endtask

    task automatic setup_run(input bit s, input int np, input logic [7:0] t, input logic [7:0] it,
                             input int sdly, input int sp, input int sn, input int hx);
        sel = s; np_cur = np; t_cur = t; i_cur = it;
        for (int k = 0; k < 8; k++) salt_cur[32*k +: 32] = $urandom();
        seed_delay = sdly; stall_party = sp; stall_left = sn; hold_extra = hx;
        exp_party = 0; acc_count = 0; hash_count = 0; done_count = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        t_round = t_cur; salt = salt_cur; i_tag = i_cur;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        t_round = 8'hA5; salt = ~salt_cur; i_tag = 8'h5A;
        chk("start_to_req", seed_req, 1);
    endtask

    task automatic run_seq(input bit s, input int np, input logic [7:0] t, input logic [7:0] it,
                           input int sdly, input int sp, input int sn, input int hx, input bit inject);
        int n;
        setup_run(s, np, t, it, sdly, sp, sn, hx);
        if (inject) begin
            seed_vld_x = 1'b1;
            @(posedge clk); #1;
            seed_vld_x = 1'b0;
            chk("stray_vld_idle", busy, 0);
        end
        pulse_start();
        if (inject) begin
            repeat (30) @(posedge clk);
            #1;
            start_r = 1'b1; t_round = 8'hEE;
            @(posedge clk); #1;
            start_r = 1'b0;
        end
        n = 0;
        while (done_count == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", n < 3000, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_count, 1);
        chk("n_commits", acc_count, np);
        chk("n_hashes", hash_count, np);
        chk("sb_empty", exp_q.size(), 0);
        chk("idle_after", busy, 0);
    endtask

    task automatic reset_mid();
        int n;
        setup_run(1'b0, 3, 8'd5, 8'h02, 0, 255, 0, 0);
        pulse_start();
        n = 0;
        while (!(hash_count == 2 && h_start) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_hash1", n < 1000, 1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_mid");
        reset = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("rst_no_cm", acc_count, 1);
        chk("rst_no_done", done_count, 0);
        chk("rst_idle", busy, 0);
    endtask

    initial begin
        chk("sm3_abc", sm3_cf(SM3_IV, ABC_BLK), ABC_DIG);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        run_seq(1'b0, 3, 8'd5, 8'h02, 0, 255, 0, 0, 1'b0);
        run_seq(1'b0, 3, 8'd5, 8'h02, 0, 1, 10, 0, 1'b0);
        run_seq(1'b0, 3, 8'd9, 8'h02, 0, 255, 0, 3, 1'b0);
        run_seq(1'b0, 3, 8'd5, 8'h02, 0, 255, 0, 0, 1'b1);
        reset_mid();
        run_seq(1'b0, 3, 8'd5, 8'h02, 0, 255, 0, 0, 1'b0);
        run_seq(1'b1, 2, 8'd5, 8'h02, 7, 255, 0, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
